rw_port_scheduler: RTL and testbench
====================================

# rw_port_scheduler

Registered scheduler that shares the single `axi_rw` request port between the instruction-fetch requester and the load/store requester of the `cpu`. It replaces the combinational `if_mem_arbiter` path in `SimTop`. The scheduler latches the winning request and holds it stable on `axi_rw` until `rw_ready`. It then returns the captured read data and response to the winner as a one-cycle pulse. Bounded-starvation priority ensures fetch progress under back-to-back memory traffic.

## Interface
- `MEM_STREAK_MAX`, default 4: number of consecutive MEM grants allowed while IF is pending; range 1–15.
- `IF_ID`, default 4'd0: value driven on `rw_id` for IF transactions.
- `MEM_ID`, default 4'd1: value driven on `rw_id` for MEM transactions.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_valid`  in  1  IF request pending.
- `if_addr`  in  64  IF address.
- `if_size`  in  2  IF access size.
- `if_req`  in  1  ignored; IF is always issued as a read.
- `if_ready`  out  1  one-cycle completion pulse to IF.
- `if_data_read`  out  64  captured read data, valid while `if_ready`=1.
- `if_resp`  out  2  captured response, valid while `if_ready`=1.
- `mem_valid`  in  1  MEM request pending.
- `mem_req`  in  1  0 = read, 1 = write.
- `mem_addr`  in  64  MEM address.
- `mem_size`  in  2  MEM access size.
- `mem_data_write`  in  64  MEM write data.
- `mem_ready`  out  1  one-cycle completion pulse to MEM.
- `mem_data_read`  out  64  captured read data, valid while `mem_ready`=1.
- `mem_resp`  out  2  captured response, valid while `mem_ready`=1.
- `rw_valid`  out  1  request to `axi_rw`.
- `rw_req`  out  1  read/write select to `axi_rw`.
- `rw_addr`  out  64  address to `axi_rw`.
- `rw_size`  out  2  size to `axi_rw`.
- `rw_data_write`  out  64  write data to `axi_rw`.
- `rw_id`  out  4  transaction ID to `axi_rw`.
- `rw_ready`  in  1  one-cycle completion strobe from `axi_rw`.
- `rw_data_read`  in  64  read data from `axi_rw`.
- `rw_resp`  in  2  response from `axi_rw`.

## Operation
- FSM states:
  - IDLE → BUSY when any request is pending.
  - BUSY → DONE when `rw_ready`=1.
  - DONE → IDLE unconditionally.
- Owner register `own`: 0 = IF, 1 = MEM. Written only on the IDLE→BUSY transition.
- Grant decision in IDLE:
  - Only one valid: grant that requester.
  - Both valid: grant MEM unless `streak` == `MEM_STREAK_MAX`, in which case grant IF.
- `streak` counter, 4 bits:
  - Increments on a MEM grant made while `if_valid`=1; saturates at `MEM_STREAK_MAX`.
  - Clears on any IF grant.
  - Clears on a MEM grant while `if_valid`=0.
- At grant, latch into the request registers: addr, size, data_write, req, and id.
  - IF grant: req forced to 0, data_write = 0, id = `IF_ID`.
  - MEM grant: req, addr, size and data_write taken from the MEM inputs, id = `MEM_ID`.
- `rw_valid`=1 exactly while in BUSY. The request registers do not change during BUSY.
- In BUSY with `rw_ready`=1: capture `rw_data_read` and `rw_resp` into the data/resp registers.
- In DONE: assert the owner's ready pulse (`if_ready` or `mem_ready`) with the captured data/resp. The non-owner's ready stays 0.
- Requester valid deasserting during BUSY is ignored. The transaction completes and the ready pulse is still issued.
- `rw_ready` outside BUSY is ignored; no state change.

## Timing
- Reset (asynchronous, `reset`=0):
  - State = IDLE, `streak` = 0, `own` = 0.
  - All outputs 0: `rw_valid`, `rw_req`, `rw_addr`, `rw_size`, `rw_data_write`, `rw_id`, both ready pulses, all data/resp outputs.
- Reset asserted mid-BUSY aborts the transaction. No ready pulse is issued.
- Latency:
  - Valid seen in IDLE at edge N → `rw_valid` high from cycle N+1.
  - `rw_ready` at cycle M → requester ready high in cycle M+1 only.
  - Minimum round trip: request to ready = 3 cycles when `rw_ready` arrives in the first BUSY cycle.
- Requesters drop or replace valid on the edge ending their ready cycle. A request still asserted in the following IDLE is treated as a new request.
- Back-to-back transactions: IDLE occupies exactly 1 cycle between DONE and the next BUSY.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Single IF fetch, `if_addr`=0x8000_0000, `rw_ready` 5 cycles after `rw_valid` with data 0x0000_0013 → `rw_id`=0, `rw_req`=0, `if_ready` pulse one cycle later with `if_data_read`=0x13, `mem_ready` stays 0.
- MEM write, addr 0x8000_1000, data 0xDEAD_BEEF, size 3 → `rw_req`=1, `rw_id`=1, `rw_data_write`=0xDEAD_BEEF stable for all BUSY cycles, `mem_ready` pulse with `mem_resp`=0.
- IF and MEM both held valid continuously, default `MEM_STREAK_MAX`=4 → grant order MEM, MEM, MEM, MEM, IF, then repeating.
- Requester valid dropped on the second BUSY cycle → `rw_addr` unchanged and the ready pulse is still issued.
- `reset` pulled low during BUSY → outputs 0 immediately. After release, IDLE with no stale ready pulse.
- `rw_ready` pulsed while in IDLE → no state change and no ready output.

Source files
------------

// File: rtl/rw_port_scheduler.sv
// rw_port_scheduler: registered arbiter sharing the axi_rw port between IF and MEM,
// with MEM streaks capped so a pending fetch is never starved.
module rw_port_scheduler #(
  parameter int MEM_STREAK_MAX = 4,
  parameter logic [3:0] IF_ID = 4'd0,
  parameter logic [3:0] MEM_ID = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_valid,
  input  logic [63:0] if_addr,
  input  logic [1:0]  if_size,
  input  logic        if_req,
  output logic        if_ready,
  output logic [63:0] if_data_read,
  output logic [1:0]  if_resp,
  input  logic        mem_valid,
  input  logic        mem_req,
  input  logic [63:0] mem_addr,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_data_write,
  output logic        mem_ready,
  output logic [63:0] mem_data_read,
  output logic [1:0]  mem_resp,
  output logic        rw_valid,
  output logic        rw_req,
  output logic [63:0] rw_addr,
  output logic [1:0]  rw_size,
  output logic [63:0] rw_data_write,
  output logic [3:0]  rw_id,
  input  logic        rw_ready,
  input  logic [63:0] rw_data_read,
  input  logic [1:0]  rw_resp
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] STREAK_MAX = 4'(MEM_STREAK_MAX);
  state_t state, state_nx;
  logic own, grant, grant_mem;
  logic [3:0] streak;
  logic [63:0] data_q;
  logic [1:0] resp_q;
  logic unused_if_req;
  assign unused_if_req = if_req;
  always_comb begin
    state_nx = state;
    grant = 1'b0;
    grant_mem = mem_valid && !(if_valid && streak == STREAK_MAX);
    grant = state == IDLE && (if_valid || mem_valid);
    state_nx = state == IDLE ? (grant ? BUSY : IDLE) : state == BUSY ? (rw_ready ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      own <= 1'b0;
      streak <= 4'd0;
      rw_req <= 1'b0;
      rw_addr <= 64'd0;
      rw_size <= 2'd0;
      rw_data_write <= 64'd0;
      rw_id <= 4'd0;
      data_q <= 64'd0;
      resp_q <= 2'd0;
    end else begin
      state <= state_nx;
      if (grant) begin
        own <= grant_mem;
        streak <= (grant_mem && if_valid) ? (streak == STREAK_MAX ? streak : streak + 4'd1) : 4'd0;
        rw_req <= grant_mem && mem_req;
        rw_addr <= grant_mem ? mem_addr : if_addr;
        rw_size <= grant_mem ? mem_size : if_size;
        rw_data_write <= grant_mem ? mem_data_write : 64'd0;
        rw_id <= grant_mem ? MEM_ID : IF_ID;
      end
      if (state == BUSY && rw_ready) begin
        data_q <= rw_data_read;
        resp_q <= rw_resp;
      end
    end
  assign rw_valid = state == BUSY;
  assign if_ready = state == DONE && !own;
  assign mem_ready = state == DONE && own;
  assign if_data_read = data_q;
  assign mem_data_read = data_q;
  assign if_resp = resp_q;
  assign mem_resp = resp_q;
endmodule

// File: tb/tb_rw_port_scheduler.sv
// tb_rw_port_scheduler: randomized requesters and memory against a transaction-level
// model of the grant policy, with a queue-based scoreboard checked by a negedge monitor.
module tb_rw_port_scheduler;
  localparam int MAX = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic if_valid = 1'b0, if_req = 1'b0, mem_valid = 1'b0, mem_req = 1'b0, rw_ready = 1'b0;
  logic [63:0] if_addr = '0, mem_addr = '0, mem_data_write = '0, rw_data_read = '0;
  logic [1:0] if_size = '0, mem_size = '0, rw_resp = '0;
  logic if_ready, mem_ready, rw_valid, rw_req;
  logic [63:0] if_data_read, mem_data_read, rw_addr, rw_data_write;
  logic [1:0] if_resp, mem_resp, rw_size;
  logic [3:0] rw_id;

  always #5 clock = ~clock;

  rw_port_scheduler #(.MEM_STREAK_MAX(MAX), .IF_ID(4'd0), .MEM_ID(4'd1)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_req(if_req),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_data_read(mem_data_read),
    .mem_resp(mem_resp), .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr),
    .rw_size(rw_size), .rw_data_write(rw_data_write), .rw_id(rw_id), .rw_ready(rw_ready),
    .rw_data_read(rw_data_read), .rw_resp(rw_resp)
  );

  typedef struct {
    logic [3:0] id;
    logic req;
    logic [63:0] addr;
    logic [1:0] size;
    logic [63:0] wdata;
  } req_t;
  typedef struct {
    logic mem;
    logic [63:0] data;
    logic [1:0] resp;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  logic [3:0] ids_seen[$];
  int checks = 0, fails = 0;

  // Transaction model: port is free, owned by an in-flight request, or in its completion gap.
  int phase = 0, mstreak = 0;
  bit m_owner = 0, gm = 0, if_wait = 0, mem_wait = 0, if_cpl = 0, mem_cpl = 0, pulse_due = 0;
  req_t mr;
  rsp_t ms;

  bit if_en = 0, mem_en = 0, if_shot = 0, mem_shot = 0, dir_if = 0, dir_mem = 0;
  bit drop_en = 0, stray_en = 0, fix_data = 0, last_v = 0;
  int rate = 100, fix_delay = -1, bcnt = 0, delay = 0;
  logic [63:0] data_val = 64'h13;
  rsp_t s;
  req_t r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rw_valid"}, 64'(rw_valid), 64'd0);
    check({tag, "_rw_req"}, 64'(rw_req), 64'd0);
    check({tag, "_rw_addr"}, rw_addr, 64'd0);
    check({tag, "_rw_size"}, 64'(rw_size), 64'd0);
    check({tag, "_rw_data_write"}, rw_data_write, 64'd0);
    check({tag, "_rw_id"}, 64'(rw_id), 64'd0);
    check({tag, "_if_ready"}, 64'(if_ready), 64'd0);
    check({tag, "_mem_ready"}, 64'(mem_ready), 64'd0);
    check({tag, "_if_data_read"}, if_data_read, 64'd0);
    check({tag, "_mem_data_read"}, mem_data_read, 64'd0);
    check({tag, "_if_resp"}, 64'(if_resp), 64'd0);
    check({tag, "_mem_resp"}, 64'(mem_resp), 64'd0);
  endtask

  always @(posedge clock or negedge reset)
    if (!reset) begin
      phase = 0; mstreak = 0; pulse_due = 0; if_cpl = 0; mem_cpl = 0; if_wait = 0; mem_wait = 0;
      req_q.delete();
      rsp_q.delete();
    end else begin
      pulse_due = 0; if_cpl = 0; mem_cpl = 0;
      if (phase == 0) begin
        if (if_valid || mem_valid) begin
          gm = mem_valid && !(if_valid && mstreak == MAX);
          mstreak = (gm && if_valid) ? mstreak + 1 : 0;
          mr.id = gm ? 4'd1 : 4'd0;
          mr.req = gm ? mem_req : 1'b0;
          mr.addr = gm ? mem_addr : if_addr;
          mr.size = gm ? mem_size : if_size;
          mr.wdata = gm ? mem_data_write : 64'd0;
          req_q.push_back(mr);
          m_owner = gm;
          if (gm) mem_wait = 1; else if_wait = 1;
          phase = 1;
        end
      end else if (phase == 1) begin
        if (rw_ready) begin
          ms.mem = m_owner; ms.data = rw_data_read; ms.resp = rw_resp;
          rsp_q.push_back(ms);
          pulse_due = 1;
          phase = 2;
        end
      end else begin
        phase = 0;
        if (m_owner) begin mem_cpl = 1; mem_wait = 0; end
        else begin if_cpl = 1; if_wait = 0; end
      end
    end

  always @(negedge clock)
    if (!reset) last_v = 0;
    else begin
      check("rw_valid", 64'(rw_valid), 64'(phase == 1));
      if (rw_valid) begin
        if (req_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL rw_request: rw_valid=1 with no expected request");
        end else begin
          r = req_q[0];
          check("rw_id", 64'(rw_id), 64'(r.id));
          check("rw_req", 64'(rw_req), 64'(r.req));
          check("rw_addr", rw_addr, r.addr);
          check("rw_size", 64'(rw_size), 64'(r.size));
          check("rw_data_write", rw_data_write, r.wdata);
        end
        if (!last_v) ids_seen.push_back(rw_id);
      end else if (last_v && req_q.size() > 0) void'(req_q.pop_front());
      last_v = rw_valid;
      check("ready_timing", 64'(if_ready | mem_ready), 64'(pulse_due));
      if (if_ready || mem_ready) begin
        if (rsp_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL ready_unexpected: if_ready=%0b mem_ready=%0b with no expected response", if_ready, mem_ready);
        end else begin
          s = rsp_q.pop_front();
          check("if_ready_owner", 64'(if_ready), 64'(!s.mem));
          check("mem_ready_owner", 64'(mem_ready), 64'(s.mem));
          check("data_read", s.mem ? mem_data_read : if_data_read, s.data);
          check("resp", 64'(s.mem ? mem_resp : if_resp), 64'(s.resp));
        end
      end
    end

  task automatic drive_cycle();
    if (!reset) begin
      if_valid = 0; mem_valid = 0; rw_ready = 0; bcnt = 0;
    end else begin
      if (if_cpl) if_valid = 0;
      if (mem_cpl) mem_valid = 0;
      if (drop_en && if_valid && if_wait && $urandom_range(0, 3) == 0) if_valid = 0;
      if (drop_en && mem_valid && mem_wait && $urandom_range(0, 3) == 0) mem_valid = 0;
      if (!if_valid && !if_wait && (if_shot || (if_en && $urandom_range(0, 99) < rate))) begin
        if_shot = 0; if_valid = 1; if_req = 1'($urandom);
        if_size = dir_if ? 2'd2 : 2'($urandom);
        if_addr = dir_if ? 64'h8000_0000 : {$urandom, $urandom};
      end
      if (!mem_valid && !mem_wait && (mem_shot || (mem_en && $urandom_range(0, 99) < rate))) begin
        mem_shot = 0; mem_valid = 1;
        mem_req = dir_mem ? 1'b1 : 1'($urandom);
        mem_size = dir_mem ? 2'd3 : 2'($urandom);
        mem_addr = dir_mem ? 64'h8000_1000 : {$urandom, $urandom};
        mem_data_write = dir_mem ? 64'hDEAD_BEEF : {$urandom, $urandom};
      end
      rw_ready = 0;
      if (rw_valid) begin
        if (bcnt >= delay) begin
          rw_ready = 1;
          rw_data_read = fix_data ? data_val : {$urandom, $urandom};
          rw_resp = fix_data ? 2'd0 : 2'($urandom);
          bcnt = 0;
        end else bcnt++;
      end else begin
        bcnt = 0;
        delay = fix_delay >= 0 ? fix_delay : int'($urandom_range(0, 4));
        if (stray_en && $urandom_range(0, 7) == 0) begin
          rw_ready = 1;
          rw_data_read = {$urandom, $urandom};
        end
      end
    end
  endtask

  task automatic wait_cpl(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(posedge clock); #2;
      if (if_cpl || mem_cpl) got++;
      cyc++;
    end
    checks++;
    if (got < n) begin
      fails++;
      $display("FAIL completion_timeout: got %0d completions, expected %0d", got, n);
    end
  endtask

  task automatic drain();
    int cyc = 0;
    while ((if_valid || mem_valid || if_wait || mem_wait || phase != 0) && cyc < 300) begin
      @(posedge clock); #2;
      cyc++;
    end
    check("drain", 64'(if_valid || mem_valid || if_wait || mem_wait || phase != 0), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_ids[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int cyc;
    fork
      forever begin
        @(posedge clock); #1;
        drive_cycle();
      end
    join_none
    #1 reset = 0;
    #2 check_zero("reset");
    if_en = 1; mem_en = 1; rate = 100;
    repeat (3) @(posedge clock);
    #2 reset = 1;
    wait_cpl(10, 300);
    for (int i = 0; i < 10; i++)
      check($sformatf("grant_order[%0d]", i), 64'(ids_seen[i]), 64'(exp_ids[i]));
    if_en = 0; mem_en = 0;
    drain();
    dir_if = 1; fix_data = 1; data_val = 64'h13; fix_delay = 5; if_shot = 1;
    wait_cpl(1, 50);
    drain();
    dir_if = 0; dir_mem = 1; fix_delay = 2; data_val = 64'h55; mem_shot = 1;
    wait_cpl(1, 50);
    drain();
    dir_mem = 0; fix_data = 0; fix_delay = -1;
    stray_en = 1;
    repeat (20) @(posedge clock);
    fix_delay = 6; mem_shot = 1;
    cyc = 0;
    while (!rw_valid && cyc < 20) begin @(posedge clock); #2; cyc++; end
    check("abort_busy_reached", 64'(rw_valid), 64'd1);
    @(posedge clock); #2 reset = 0;
    #1 check_zero("abort");
    repeat (3) @(posedge clock);
    #2 reset = 1; fix_delay = -1;
    repeat (10) @(posedge clock);
    if_en = 1; mem_en = 1; rate = 40; drop_en = 1;
    repeat (3000) @(posedge clock);
    if_en = 0; mem_en = 0; stray_en = 0;
    drain();
    repeat (3) @(posedge clock);
    #2;
    check("req_q_empty", 64'(req_q.size()), 64'd0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
